// File: rtl/tot_pattern_gen.sv
// tot_pattern_gen: synthetic PMT square-pulse source for the 40 MHz ToT trigger path.
// On START it latches the burst parameters and plays LEAD baseline ticks, then
// NPULSES pulses of max(PULSE_LEN,1) ticks, separated by max(GAP,1) baseline ticks.
// The state machine advances only on 40 MHz ticks (ENABLE40 == 0). All outputs are
// registered and are refreshed on every CLK120 edge.
// Optional build macro TOT_PATGEN_NOISE_EN adds 0..3 LSB of LFSR noise to every
// sample, saturating at full scale. Without the macro no LFSR is built.
module tot_pattern_gen #(
  parameter int ADC_WIDTH = 12,
  parameter int CNT_WIDTH = 7,
  parameter int LEN_WIDTH = 4
) (
  input  logic                 CLK120,
  input  logic                 RESET,
  input  logic [1:0]           ENABLE40,
  input  logic                 START,
  input  logic [ADC_WIDTH-1:0] BASELINE,
  input  logic [ADC_WIDTH-1:0] AMPLITUDE,
  input  logic [2:0]           PMT_MASK,
  input  logic [CNT_WIDTH-1:0] NPULSES,
  input  logic [LEN_WIDTH-1:0] PULSE_LEN,
  input  logic [LEN_WIDTH-1:0] GAP,
  input  logic [LEN_WIDTH-1:0] LEAD,
  output logic [ADC_WIDTH-1:0] ADC0,
  output logic [ADC_WIDTH-1:0] ADC1,
  output logic [ADC_WIDTH-1:0] ADC2,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PULSE_ACTIVE
);

  // Generator states
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEAD = 3'd1;
  localparam logic [2:0] S_HIGH = 3'd2;
  localparam logic [2:0] S_LOW  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  // Hold counters count down to zero and the state is left on the tick that
  // finds them at zero, so a hold of k ticks loads k-1. A zero length is
  // treated as one tick so every phase lasts at least one 40 MHz period.
  function automatic logic [LEN_WIDTH-1:0] f_hold_load(input logic [LEN_WIDTH-1:0] len);
    logic [LEN_WIDTH-1:0] res;
    if (len == {LEN_WIDTH{1'b0}}) begin
      res = {LEN_WIDTH{1'b0}};
    end else begin
      res = len - LEN_WIDTH'(1);
    end
    return res;
  endfunction

  // Current state and counters
  logic [2:0]           r_state;
  logic [LEN_WIDTH-1:0] r_hold;
  logic [CNT_WIDTH-1:0] r_pulses;

  // Parameters latched when a burst is accepted
  logic [ADC_WIDTH-1:0] r_amp;
  logic [ADC_WIDTH-1:0] r_base;
  logic [2:0]           r_mask;
  logic [LEN_WIDTH-1:0] r_plen;
  logic [LEN_WIDTH-1:0] r_gap;

  // Registered outputs
  logic [ADC_WIDTH-1:0] r_adc0;
  logic [ADC_WIDTH-1:0] r_adc1;
  logic [ADC_WIDTH-1:0] r_adc2;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pulse_active;

  // Next-state values
  logic                 w_tick;
  logic                 w_accept;
  logic [2:0]           w_state_nxt;
  logic [LEN_WIDTH-1:0] w_hold_nxt;
  logic [CNT_WIDTH-1:0] w_pulses_nxt;

  // Sample selection
  logic                 w_high;
  logic [ADC_WIDTH-1:0] w_base_sel;
  logic [ADC_WIDTH-1:0] w_adc0_raw;
  logic [ADC_WIDTH-1:0] w_adc1_raw;
  logic [ADC_WIDTH-1:0] w_adc2_raw;
  logic [ADC_WIDTH-1:0] w_adc0_q;
  logic [ADC_WIDTH-1:0] w_adc1_q;
  logic [ADC_WIDTH-1:0] w_adc2_q;

  assign w_tick = (ENABLE40 == 2'd0);

  // Burst sequencing: state transitions, hold countdown and remaining-pulse count
  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold;
    w_pulses_nxt = r_pulses;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_accept     = 1'b1;
          w_pulses_nxt = NPULSES;
          w_hold_nxt   = f_hold_load(LEAD);
          if (NPULSES == {CNT_WIDTH{1'b0}}) begin
            w_state_nxt = S_FIN;
          end else begin
            w_state_nxt = S_LEAD;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LEAD: begin
        if (w_tick) begin
          if (r_hold == {LEN_WIDTH{1'b0}}) begin
            w_state_nxt = S_HIGH;
            w_hold_nxt  = f_hold_load(r_plen);
          end else begin
            w_hold_nxt = r_hold - LEN_WIDTH'(1);
          end
        end else begin
          w_hold_nxt = r_hold;
        end
      end
      S_HIGH: begin
        if (w_tick) begin
          if (r_hold == {LEN_WIDTH{1'b0}}) begin
            // Pulse finished: consume one from the burst, never wrapping below 0
            if (r_pulses == {CNT_WIDTH{1'b0}}) begin
              w_pulses_nxt = {CNT_WIDTH{1'b0}};
            end else begin
              w_pulses_nxt = r_pulses - CNT_WIDTH'(1);
            end
            if (r_pulses > CNT_WIDTH'(1)) begin
              w_state_nxt = S_LOW;
              w_hold_nxt  = f_hold_load(r_gap);
            end else begin
              w_state_nxt = S_FIN;
              w_hold_nxt  = {LEN_WIDTH{1'b0}};
            end
          end else begin
            w_hold_nxt = r_hold - LEN_WIDTH'(1);
          end
        end else begin
          w_hold_nxt = r_hold;
        end
      end
      S_LOW: begin
        if (w_tick) begin
          if (r_hold == {LEN_WIDTH{1'b0}}) begin
            w_state_nxt = S_HIGH;
            w_hold_nxt  = f_hold_load(r_plen);
          end else begin
            w_hold_nxt = r_hold - LEN_WIDTH'(1);
          end
        end else begin
          w_hold_nxt = r_hold;
        end
      end
      S_FIN: begin
        // DONE is issued from this state on the edge that returns to IDLE
        w_state_nxt  = S_IDLE;
        w_hold_nxt   = {LEN_WIDTH{1'b0}};
        w_pulses_nxt = {CNT_WIDTH{1'b0}};
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_hold_nxt   = {LEN_WIDTH{1'b0}};
        w_pulses_nxt = {CNT_WIDTH{1'b0}};
      end
    endcase
  end

  // State register, counters and parameter latches captured on an accepted START
  always_ff @(posedge CLK120) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_hold   <= {LEN_WIDTH{1'b0}};
      r_pulses <= {CNT_WIDTH{1'b0}};
      r_amp    <= {ADC_WIDTH{1'b0}};
      r_base   <= {ADC_WIDTH{1'b0}};
      r_mask   <= 3'b000;
      r_plen   <= {LEN_WIDTH{1'b0}};
      r_gap    <= {LEN_WIDTH{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_hold   <= w_hold_nxt;
      r_pulses <= w_pulses_nxt;
      if (w_accept) begin
        r_amp  <= AMPLITUDE;
        r_base <= BASELINE;
        r_mask <= PMT_MASK;
        r_plen <= PULSE_LEN;
        r_gap  <= GAP;
      end
    end
  end

  // Per-channel sample: latched amplitude on enabled channels in HIGH, else baseline.
  // In IDLE the live baseline is followed so the idle level tracks the input.
  always_comb begin
    w_high = (r_state == S_HIGH);
    if (r_state == S_IDLE) begin
      w_base_sel = BASELINE;
    end else begin
      w_base_sel = r_base;
    end
    if (w_high && r_mask[0]) begin
      w_adc0_raw = r_amp;
    end else begin
      w_adc0_raw = w_base_sel;
    end
    if (w_high && r_mask[1]) begin
      w_adc1_raw = r_amp;
    end else begin
      w_adc1_raw = w_base_sel;
    end
    if (w_high && r_mask[2]) begin
      w_adc2_raw = r_amp;
    end else begin
      w_adc2_raw = w_base_sel;
    end
  end

`ifdef TOT_PATGEN_NOISE_EN
  // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
  function automatic logic [15:0] f_lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  // Add a small unsigned noise value, clamping at full scale
  function automatic logic [ADC_WIDTH-1:0] f_sat_add(input logic [ADC_WIDTH-1:0] a,
                                                     input logic [1:0]           n);
    logic [ADC_WIDTH:0] sum;
    sum = {1'b0, a} + {{(ADC_WIDTH-1){1'b0}}, n};
    if (sum[ADC_WIDTH]) begin
      return {ADC_WIDTH{1'b1}};
    end else begin
      return sum[ADC_WIDTH-1:0];
    end
  endfunction

  logic [15:0] r_lfsr;

  // Noise source: seeded on reset, stepped once per 40 MHz tick
  always_ff @(posedge CLK120) begin
    if (RESET) begin
      r_lfsr <= 16'hACE1;
    end else if (w_tick) begin
      r_lfsr <= f_lfsr_next(r_lfsr);
    end else begin
      r_lfsr <= r_lfsr;
    end
  end

  assign w_adc0_q = f_sat_add(w_adc0_raw, r_lfsr[1:0]);
  assign w_adc1_q = f_sat_add(w_adc1_raw, r_lfsr[1:0]);
  assign w_adc2_q = f_sat_add(w_adc2_raw, r_lfsr[1:0]);
`else
  assign w_adc0_q = w_adc0_raw;
  assign w_adc1_q = w_adc1_raw;
  assign w_adc2_q = w_adc2_raw;
`endif

  // Output registers: samples, handshake flags and the pulse marker
  always_ff @(posedge CLK120) begin
    if (RESET) begin
      r_adc0         <= {ADC_WIDTH{1'b0}};
      r_adc1         <= {ADC_WIDTH{1'b0}};
      r_adc2         <= {ADC_WIDTH{1'b0}};
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pulse_active <= 1'b0;
    end else begin
      r_adc0         <= w_adc0_q;
      r_adc1         <= w_adc1_q;
      r_adc2         <= w_adc2_q;
      r_busy         <= (w_state_nxt != S_IDLE);
      r_done         <= (r_state == S_FIN);
      r_pulse_active <= w_high;
    end
  end

  assign ADC0         = r_adc0;
  assign ADC1         = r_adc1;
  assign ADC2         = r_adc2;
  assign BUSY         = r_busy;
  assign DONE         = r_done;
  assign PULSE_ACTIVE = r_pulse_active;

endmodule

// File: tb/tb_tot_pattern_gen.sv
// Self-checking bench for tot_pattern_gen. A tick-counting reference model
// derives every expected sample from the burst arithmetic (lead, pulse and gap
// windows in ticks since START) and is compared against the DUT every cycle.
module tb_tot_pattern_gen;
  localparam int AW = 12;
  localparam int CW = 7;
  localparam int LW = 4;

  logic          CLK120;
  logic          RESET;
  logic [1:0]    ENABLE40;
  logic          START;
  logic [AW-1:0] BASELINE;
  logic [AW-1:0] AMPLITUDE;
  logic [2:0]    PMT_MASK;
  logic [CW-1:0] NPULSES;
  logic [LW-1:0] PULSE_LEN;
  logic [LW-1:0] GAP;
  logic [LW-1:0] LEAD;
  logic [AW-1:0] ADC0;
  logic [AW-1:0] ADC1;
  logic [AW-1:0] ADC2;
  logic          BUSY;
  logic          DONE;
  logic          PULSE_ACTIVE;

  tot_pattern_gen #(.ADC_WIDTH(AW), .CNT_WIDTH(CW), .LEN_WIDTH(LW)) dut (
    .CLK120(CLK120), .RESET(RESET), .ENABLE40(ENABLE40), .START(START),
    .BASELINE(BASELINE), .AMPLITUDE(AMPLITUDE), .PMT_MASK(PMT_MASK),
    .NPULSES(NPULSES), .PULSE_LEN(PULSE_LEN), .GAP(GAP), .LEAD(LEAD),
    .ADC0(ADC0), .ADC1(ADC1), .ADC2(ADC2),
    .BUSY(BUSY), .DONE(DONE), .PULSE_ACTIVE(PULSE_ACTIVE)
  );

  initial begin
    CLK120 = 1'b0;
    forever #5 CLK120 = ~CLK120;
  end

  int compared   = 0;
  int mismatched = 0;

  // Reference model: mode 0 idle, 1 running, 2 finishing
  int          m_mode = 0;
  int          m_t    = 0;
  int          m_tend = 0;
  int          m_lead = 1;
  int          m_plen = 1;
  int          m_gap  = 1;
  int          m_amp  = 0;
  int          m_base = 0;
  logic [2:0]  m_mask = 3'b000;
  int          m_lfsr = 16'hACE1;

  // Observation statistics
  int   done_seen = 0;
  int   pa_rises  = 0;
  int   pa_cycles = 0;
  logic pa_prev   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_pulse(input int t);
    int per;
    per = m_plen + m_gap;
    return (t >= m_lead) && (t < m_tend) && (((t - m_lead) % per) < m_plen);
  endfunction

  task automatic clear_stats();
    done_seen = 0;
    pa_rises  = 0;
    pa_cycles = 0;
  endtask

  // One CLK120 cycle: predict, clock, compare all outputs, advance the 40 MHz phase
  task automatic step();
    int   e_adc[3];
    logic e_busy, e_done, e_pa;
    bit   hi, tick;
    int   base, n, fb;
    tick = (ENABLE40 == 2'd0);
    if (RESET) begin
      for (int i = 0; i < 3; i++) e_adc[i] = 0;
      e_busy = 1'b0; e_done = 1'b0; e_pa = 1'b0;
      m_mode = 0; m_t = 0; m_lfsr = 16'hACE1;
    end else begin
      hi   = (m_mode == 1) && in_pulse(m_t);
      base = (m_mode == 0) ? int'(BASELINE) : m_base;
      for (int i = 0; i < 3; i++) begin
        e_adc[i] = (hi && m_mask[i]) ? m_amp : base;
`ifdef TOT_PATGEN_NOISE_EN
        e_adc[i] = e_adc[i] + (m_lfsr % 4);
        if (e_adc[i] > 4095) e_adc[i] = 4095;
`endif
      end
      e_pa   = hi;
      e_done = (m_mode == 2);
      case (m_mode)
        0: if (START) begin
          m_amp  = int'(AMPLITUDE);
          m_base = int'(BASELINE);
          m_mask = PMT_MASK;
          n      = int'(NPULSES);
          m_lead = (LEAD == 0) ? 1 : int'(LEAD);
          m_plen = (PULSE_LEN == 0) ? 1 : int'(PULSE_LEN);
          m_gap  = (GAP == 0) ? 1 : int'(GAP);
          m_tend = m_lead + n * m_plen + (n - 1) * m_gap;
          m_t    = 0;
          m_mode = (n == 0) ? 2 : 1;
        end
        1: if (tick) begin
          m_t++;
          if (m_t == m_tend) m_mode = 2;
        end
        default: m_mode = 0;
      endcase
      if (tick) begin
        fb     = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = (m_lfsr >> 1) | (fb << 15);
      end
      e_busy = (m_mode != 0);
    end
    @(posedge CLK120);
    #1;
    check("adc0", 32'(ADC0), e_adc[0]);
    check("adc1", 32'(ADC1), e_adc[1]);
    check("adc2", 32'(ADC2), e_adc[2]);
    check("busy", 32'(BUSY), 32'(e_busy));
    check("done", 32'(DONE), 32'(e_done));
    check("pulse_active", 32'(PULSE_ACTIVE), 32'(e_pa));
    if (DONE === 1'b1) done_seen++;
    if (PULSE_ACTIVE === 1'b1) pa_cycles++;
    if (PULSE_ACTIVE === 1'b1 && pa_prev !== 1'b1) pa_rises++;
    pa_prev  = PULSE_ACTIVE;
    ENABLE40 = (ENABLE40 == 2'd2) ? 2'd0 : ENABLE40 + 2'd1;
  endtask

  task automatic fire_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while (BUSY === 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(BUSY), 32'd0);
  endtask

  task automatic rand_inputs();
    BASELINE  = AW'($urandom_range(0, 4095));
    AMPLITUDE = AW'($urandom_range(0, 4095));
    PMT_MASK  = 3'($urandom_range(0, 7));
    NPULSES   = CW'($urandom_range(0, 12));
    PULSE_LEN = LW'($urandom_range(0, 15));
    GAP       = LW'($urandom_range(0, 15));
    LEAD      = LW'($urandom_range(0, 15));
  endtask

  initial begin
    int n_exp, guard, budget;
    RESET = 1'b1; START = 1'b0; ENABLE40 = 2'd0;
    BASELINE = 12'd50; AMPLITUDE = 12'd900; PMT_MASK = 3'b111;
    NPULSES = 7'd1; PULSE_LEN = 4'd3; GAP = 4'd0; LEAD = 4'd2;

    // Reset then idle at the live baseline
    repeat (3) step();
    RESET = 1'b0;
    repeat (4) step();
`ifndef TOT_PATGEN_NOISE_EN
    check("idle_baseline", 32'(ADC1), 32'd50);
`endif

    // Single pulse: 3 ticks high = 9 CLK120 cycles, one DONE
    clear_stats();
    fire_start();
    run_until_idle("single_end", 200);
    repeat (3) step();
    check("single_pa_cycles", pa_cycles, 9);
    check("single_done", done_seen, 1);

    // Masked burst, zero gap forced to one tick
    NPULSES = 7'd4; PULSE_LEN = 4'd2; GAP = 4'd0; PMT_MASK = 3'b101;
    clear_stats();
    fire_start();
    run_until_idle("mask_end", 300);
    repeat (3) step();
    check("mask_pulses", pa_rises, 4);
    check("mask_pa_cycles", pa_cycles, 24);
    check("mask_done", done_seen, 1);

    // Zero pulse count: DONE on the next-but-one cycle
    NPULSES = 7'd0;
    clear_stats();
    fire_start();
    step();
    check("zero_done_timing", 32'(DONE), 32'd1);
    repeat (4) step();
    check("zero_no_pulse", pa_cycles, 0);
    check("zero_done_count", done_seen, 1);

    // START during a burst is ignored
    NPULSES = 7'd5; PULSE_LEN = 4'd1; GAP = 4'd2; LEAD = 4'd1; PMT_MASK = 3'b111;
    clear_stats();
    fire_start();
    repeat (10) step();
    NPULSES = 7'd9;
    fire_start();
    run_until_idle("restart_end", 300);
    repeat (3) step();
    check("restart_pulses", pa_rises, 5);
    check("restart_done", done_seen, 1);

    // Reset during the second pulse of a ten-pulse burst
    NPULSES = 7'd10; PULSE_LEN = 4'd3; GAP = 4'd1;
    clear_stats();
    fire_start();
    guard = 0;
    while (pa_rises < 2 && guard < 200) begin
      step();
      guard++;
    end
    check("reach_second_pulse", pa_rises, 2);
    RESET = 1'b1;
    step();
    check("reset_adc0", 32'(ADC0), 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    RESET = 1'b0;
    repeat (6) step();
    check("reset_no_done", done_seen, 0);
    clear_stats();
    fire_start();
    run_until_idle("after_reset_end", 600);
    repeat (3) step();
    check("after_reset_pulses", pa_rises, 10);
    check("after_reset_done", done_seen, 1);

    // Full-range count with minimum lengths
    NPULSES = 7'd127; PULSE_LEN = 4'd0; GAP = 4'd0; LEAD = 4'd0;
    clear_stats();
    fire_start();
    run_until_idle("max_count_end", 2000);
    repeat (3) step();
    check("max_count_pulses", pa_rises, 127);

    // Randomized bursts with input churn and stray STARTs while busy
    for (int it = 0; it < 25; it++) begin
      rand_inputs();
      n_exp = int'(NPULSES);
      repeat ($urandom_range(0, 4)) step();
      clear_stats();
      fire_start();
      budget = 0;
      while (BUSY === 1'b1 && budget < 5000) begin
        if ($urandom_range(0, 3) == 0) rand_inputs();
        START = ($urandom_range(0, 7) == 0);
        step();
        budget++;
      end
      START = 1'b0;
      check("rand_end", 32'(BUSY), 32'd0);
      repeat (3) step();
      check("rand_pulses", pa_rises, n_exp);
      check("rand_done", done_seen, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/tot_pattern_gen.md
Name: tot_pattern_gen

Overview:
Synthetic PMT waveform source for the 40 MHz compatibility ToT trigger path. On START it drives three ADC-format sample streams with a programmed burst of square pulses. Pulse count, pulse width, gap and channel mask are all programmable. Its outputs feed the ToT trigger inputs (via the trigger input mux) for in-situ calibration of threshold, multiplicity and occupancy settings.

Parameters:
ADC_WIDTH, 12, sample width; matches `ADC_WIDTH from sde_trigger_defs.vh.
CNT_WIDTH, 7, width of pulse-count field; matches the ToT occupancy width.
LEN_WIDTH, 4, width of the pulse-length, gap and lead fields.

Ports:
CLK120  input  1  120 MHz system clock.
RESET  input  1  synchronous, active-high reset.
ENABLE40  input  2  40 MHz phase; generator advances only on ticks where ENABLE40==0.
START  input  1  single-cycle request; sampled in IDLE only.
BASELINE  input  ADC_WIDTH  level outside pulses.
AMPLITUDE  input  ADC_WIDTH  level during pulses.
PMT_MASK  input  3  bit n enables pulses on ADCn.
NPULSES  input  CNT_WIDTH  number of pulses in the burst.
PULSE_LEN  input  LEN_WIDTH  pulse high time, in 40 MHz ticks.
GAP  input  LEN_WIDTH  low time between pulses, in 40 MHz ticks.
LEAD  input  LEN_WIDTH  baseline ticks between START and the first pulse.
ADC0, ADC1, ADC2  output  ADC_WIDTH each  generated samples, registered.
BUSY  output  1  high from accepted START until DONE.
DONE  output  1  one CLK120-cycle pulse at burst end.
PULSE_ACTIVE  output  1  high while in HIGH state; used as a bench and scope marker.

Behaviour:
- Reset state: ADC0..2=0, BUSY=0, DONE=0, PULSE_ACTIVE=0, FSM=IDLE, all counters 0.
- Reset asserted mid-burst forces the reset state on the next edge; the burst is discarded and no DONE is issued.
- Parameter latching: on START in IDLE, NPULSES, PULSE_LEN, GAP, LEAD, AMPLITUDE, BASELINE and PMT_MASK are latched. Later input changes have no effect until the next START.
- START is accepted on any CLK120 cycle in IDLE, regardless of ENABLE40. BUSY rises on the next edge.
- START outside IDLE is ignored; there is no queueing.
- Tick: a CLK120 cycle with ENABLE40==0. All FSM state counters advance only on ticks.
- FSM states and transitions:
  - IDLE: on START go to LEAD, or to FIN if latched NPULSES==0.
  - LEAD: hold LEAD ticks, then go to HIGH. LEAD==0 means go to HIGH on the first tick.
  - HIGH: hold max(PULSE_LEN,1) ticks; decrement the remaining-pulse count on exit. Go to LOW if remaining>0, else to FIN.
  - LOW: hold max(GAP,1) ticks, then go to HIGH. A gap of 0 is forced to 1 so that pulses stay distinct for the ToT window.
  - FIN: assert DONE for exactly one CLK120 cycle, deassert BUSY, return to IDLE on the same edge.
- Outputs, registered and updated every CLK120 cycle:
  - ADCn = latched AMPLITUDE when state==HIGH and PMT_MASK[n]==1.
  - Otherwise ADCn = BASELINE. In IDLE this is the live BASELINE input; while BUSY it is the latched value.
  - ADC values are held constant across the three CLK120 cycles of each 40 MHz period.
- Latency: the first HIGH sample appears on the ADC outputs one CLK120 cycle after the tick on which LEAD expires.
- Total burst length = LEAD + NPULSES*max(PULSE_LEN,1) + (NPULSES-1)*max(GAP,1) ticks.
- Width rules: counters are unsigned. NPULSES is full range 0..2^CNT_WIDTH-1 with no wrap; the pulse counter stops at 0.
- PULSE_ACTIVE = (state==HIGH), registered and aligned with the ADC outputs.

Optional Feature:
TOT_PATGEN_NOISE_EN
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded to 16'hACE1 on RESET and stepped on every tick.
  - Its low 2 bits (0..3) are added to every ADC output sample, saturating at 2^ADC_WIDTH-1.
  - All three channels use the same noise value.
- Undefined: no LFSR is built, and outputs are exactly BASELINE or AMPLITUDE.
- Bench expectations must be computed from the same LFSR model when the macro is defined.

Test Plan:
1. Reset then idle: RESET for 3 cycles, BASELINE=50 -> ADC0..2=0 during reset, ADC0..2=50 from the first cycle after reset; BUSY=0, DONE=0.
2. Single pulse: BASELINE=50, AMPLITUDE=900, PMT_MASK=3'b111, NPULSES=1, PULSE_LEN=3, LEAD=2, START -> after 2 baseline ticks, all ADCs=900 for exactly 9 CLK120 cycles, then 50. DONE pulses once; BUSY is high for 5 ticks plus entry/exit cycles.
3. Burst with mask: NPULSES=4, PULSE_LEN=2, GAP=0, PMT_MASK=3'b101 -> ADC0 and ADC2 show 4 pulses of 6 cycles separated by 3-cycle gaps; ADC1 stays at BASELINE. PULSE_ACTIVE toggles 4 times.
4. Zero count and START while busy: NPULSES=0, START -> DONE on the next-but-one cycle and no pulse. Then NPULSES=5 with a second START pulsed mid-burst -> exactly 5 pulses and one DONE.
5. Reset mid-operation: assert RESET during the 2nd pulse of NPULSES=10 -> outputs 0, BUSY=0 on the next edge, no DONE. A new START after reset runs a full burst.
6. ToT loopback: connect to the ToT trigger with THRES=100, MULTIPLICITY=2, OCCUPANCY=12, PMT_MASK=3'b011, NPULSES=13, PULSE_LEN=1, GAP=1 -> the ToT trigger fires once. Repeating with NPULSES=12 -> no trigger.
